branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup for IF; one resolved-branch update per cycle plus statistics counters.
module branch_predictor #(
    parameter int         ENTRIES  = 64,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_is_jump,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    input  logic        flush_all,
    output logic        mispredict,
    output logic [31:0] upd_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         cnt_mem    [ENTRIES];
    logic               jump_mem   [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       cnt_next;
    logic             table_wr;
    logic             unused_pc_bits;

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    assign pred_taken  = lk_hit && (jump_mem[lk_idx] || cnt_mem[lk_idx][1]);
    assign pred_target = pred_taken ? target_mem[lk_idx] : lookup_pc + 32'd4;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];
    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    // NOTE: every variable assigned in always_comb gets a value first, so no latch is inferred.
    always_comb begin
        cnt_next = cnt_mem[up_idx];
        if (upd_taken) begin
            if (cnt_next != 2'b11) cnt_next = cnt_next + 2'd1;
        end else begin
            if (cnt_next != 2'b00) cnt_next = cnt_next - 2'd1;
        end
    end

    // A miss that was not taken leaves the table alone; flush discards the update.
    assign table_wr = upd_valid && !flush_all && (up_hit || upd_taken);

    // NOTE: the payload arrays carry no reset; an entry is only visible through its valid bit,
    // which reset and flush clear, so stale payload behind a clear valid bit is harmless.
    always_ff @(posedge clk) begin
        if (table_wr) begin
            cnt_mem[up_idx] <= up_hit ? cnt_next : CNT_INIT;
            if (upd_taken) begin
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target;
                jump_mem[up_idx]   <= upd_is_jump;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (upd_valid && upd_taken) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Statistics ignore flush_all and stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_cnt     <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid && (upd_cnt != 32'hFFFF_FFFF)) upd_cnt <= upd_cnt + 32'd1;
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a model-driven random run,
// with expected predictions queued at drive time and popped when the outputs are sampled.
module tb_branch_predictor;
    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_is_jump;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] upd_cnt;
    logic [31:0] mispred_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_upd  = '0;
    logic [31:0] exp_mis  = '0;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        tk;
        logic        jmp;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        fl;
        logic [31:0] lpc;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        e_mis;
    } step_t;

    exp_t sb[$];

    // Reference model of the table, indexed for ENTRIES=64 (index pc[7:2], tag pc[31:8]).
    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    logic [1:0]  m_cnt   [64];
    logic        m_jmp   [64];

    branch_predictor #(.ENTRIES(64)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_is_jump    (upd_is_jump),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .flush_all      (flush_all),
        .mispredict     (mispredict),
        .upd_cnt        (upd_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input step_t s);
        @(negedge clk);
        upd_valid       = s.v;
        upd_pc          = s.pc;
        upd_taken       = s.tk;
        upd_is_jump     = s.jmp;
        upd_target      = s.tgt;
        upd_pred_taken  = s.ptk;
        upd_pred_target = s.ptgt;
        flush_all       = s.fl;
        lookup_pc       = s.lpc;
        sb.push_back('{s.e_tk, s.e_tgt, s.e_mis});
        if (s.v && exp_upd != 32'hFFFF_FFFF) exp_upd = exp_upd + 32'd1;
        if (s.e_mis && exp_mis != 32'hFFFF_FFFF) exp_mis = exp_mis + 32'd1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        upd_valid = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        int   i;
        logic hit;
        i   = int'(pc[7:2]);
        hit = m_valid[i] && (m_tag[i] == pc[31:8]);
        tk  = hit && (m_jmp[i] || m_cnt[i][1]);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_update(input step_t s);
        int   i;
        logic hit;
        i   = int'(s.pc[7:2]);
        hit = m_valid[i] && (m_tag[i] == s.pc[31:8]);
        if (s.fl) begin
            for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
        end else if (s.v) begin
            if (hit && s.tk) begin
                if (m_cnt[i] != 2'd3) m_cnt[i] = m_cnt[i] + 2'd1;
                m_tgt[i] = s.tgt;
                m_jmp[i] = s.jmp;
            end else if (hit) begin
                if (m_cnt[i] != 2'd0) m_cnt[i] = m_cnt[i] - 2'd1;
            end else if (s.tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = s.pc[31:8];
                m_tgt[i]   = s.tgt;
                m_cnt[i]   = 2'b10;
                m_jmp[i]   = s.jmp;
            end
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        lookup_pc = 32'h0000_0100;
        #2;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0104) begin
            failures++;
            $display("FAIL reset_pred: got %b/%h want 0/00000104", pred_taken, pred_target);
        end
        checks++;
        if (upd_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got upd=%h mis=%h want 0/0", upd_cnt, mispred_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_alloc();
        step_t steps [2];
        exp_t  got;
        steps = '{
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h80,  1'b0}
        };
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            got = sb.pop_front();
            checks++;
            if ({pred_taken, pred_target, mispredict} !== {got.taken, got.target, got.mis}) begin
                failures++;
                $display("FAIL alloc[%0d]: got %b/%h mis=%b want %b/%h mis=%b", i,
                         pred_taken, pred_target, mispredict, got.taken, got.target, got.mis);
            end
        end
        checks++;
        if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL alloc_cnt: got upd=%0d mis=%0d want %0d/%0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
        end
    endtask

    task automatic test_counter_sat();
        step_t steps [11];
        exp_t  got;
        steps = '{
            '{1'b1, 32'h100, 1'b0, 1'b0, 32'hDEAD_0000, 1'b1, 32'h80,  1'b0, 32'h100, 1'b1, 32'h80,  1'b1},
            '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,         1'b0, 32'h104, 1'b0, 32'h100, 1'b0, 32'h104, 1'b0},
            '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,         1'b0, 32'h104, 1'b0, 32'h100, 1'b0, 32'h104, 1'b0},
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h80,        1'b0, 32'h104, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1},
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h80,        1'b0, 32'h104, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1},
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h80,        1'b1, 32'h80,  1'b0, 32'h100, 1'b1, 32'h80,  1'b0},
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h80,        1'b1, 32'h80,  1'b0, 32'h100, 1'b1, 32'h80,  1'b0},
            '{1'b1, 32'h100, 1'b0, 1'b0, 32'hDEAD_0000, 1'b1, 32'h80,  1'b0, 32'h100, 1'b1, 32'h80,  1'b1},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h80,  1'b0},
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h90,        1'b1, 32'h80,  1'b0, 32'h100, 1'b1, 32'h80,  1'b1},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h90,  1'b0}
        };
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            got = sb.pop_front();
            checks++;
            if ({pred_taken, pred_target, mispredict} !== {got.taken, got.target, got.mis}) begin
                failures++;
                $display("FAIL counter[%0d]: got %b/%h mis=%b want %b/%h mis=%b", i,
                         pred_taken, pred_target, mispredict, got.taken, got.target, got.mis);
            end
        end
        checks++;
        if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL counter_cnt: got upd=%0d mis=%0d want %0d/%0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
        end
    endtask

    task automatic test_alias();
        step_t steps [6];
        exp_t  got;
        steps = '{
            '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 1'b0, 32'h204, 1'b0, 32'h200, 1'b0, 32'h204, 1'b1},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h104, 1'b0},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h200, 1'b1, 32'h300, 1'b0},
            '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h104, 1'b0},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h200, 1'b1, 32'h300, 1'b0}
        };
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            got = sb.pop_front();
            checks++;
            if ({pred_taken, pred_target, mispredict} !== {got.taken, got.target, got.mis}) begin
                failures++;
                $display("FAIL alias[%0d]: got %b/%h mis=%b want %b/%h mis=%b", i,
                         pred_taken, pred_target, mispredict, got.taken, got.target, got.mis);
            end
        end
    endtask

    task automatic test_jump_flush();
        step_t steps [12];
        exp_t  got;
        steps = '{
            '{1'b1, 32'h40, 1'b1, 1'b1, 32'h400, 1'b0, 32'h44,  1'b0, 32'h40,  1'b0, 32'h44,  1'b1},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h40,  1'b1, 32'h400, 1'b1},
            '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h40,  1'b1, 32'h400, 1'b1},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h40,  1'b1, 32'h400, 1'b0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h40,  1'b1, 32'h400, 1'b0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h40,  1'b1, 32'h400, 1'b0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h40,  1'b1, 32'h400, 1'b0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 32'h400, 1'b0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h40,  1'b0, 32'h44,  1'b0},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h204, 1'b0},
            '{1'b1, 32'h80, 1'b1, 1'b0, 32'h500, 1'b0, 32'h84,  1'b1, 32'h80,  1'b0, 32'h84,  1'b1},
            '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h80,  1'b0, 32'h84,  1'b0}
        };
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            got = sb.pop_front();
            checks++;
            if ({pred_taken, pred_target, mispredict} !== {got.taken, got.target, got.mis}) begin
                failures++;
                $display("FAIL jump_flush[%0d]: got %b/%h mis=%b want %b/%h mis=%b", i,
                         pred_taken, pred_target, mispredict, got.taken, got.target, got.mis);
            end
            if (i == 8) begin
                checks++;
                if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
                    failures++;
                    $display("FAIL flush_keeps_cnt: got upd=%0d mis=%0d want %0d/%0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
                end
            end
        end
        checks++;
        if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL flush_update_cnt: got upd=%0d mis=%0d want %0d/%0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
        end
    endtask

    task automatic test_back_to_back();
        step_t steps [2];
        exp_t  got;
        steps = '{
            '{1'b1, 32'h100, 1'b1, 1'b0, 32'h180, 1'b0, 32'h104, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1},
            '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h180, 1'b0}
        };
        foreach (steps[i]) begin
            drive(steps[i]);
            #2;
            got = sb.pop_front();
            checks++;
            if ({pred_taken, pred_target, mispredict} !== {got.taken, got.target, got.mis}) begin
                failures++;
                $display("FAIL same_cycle[%0d]: got %b/%h mis=%b want %b/%h mis=%b", i,
                         pred_taken, pred_target, mispredict, got.taken, got.target, got.mis);
            end
        end
        checks++;
        if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL same_cycle_cnt: got upd=%0d mis=%0d want %0d/%0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
    endfunction

    task automatic test_random();
        step_t s;
        exp_t  got;
        int    bad = 0;
        // Start both table and model from an empty state.
        @(negedge clk);
        upd_valid = 1'b0;
        flush_all = 1'b1;
        for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            s.lpc = rand_pc();
            s.pc  = rand_pc();
            s.v   = ($urandom_range(0, 3) != 0);
            s.jmp = ($urandom_range(0, 4) == 0);
            s.tk  = s.jmp || ($urandom_range(0, 1) == 1);
            s.tgt = 32'($urandom_range(0, 1023) << 2);
            s.fl  = ($urandom_range(0, 40) == 0);
            model_pred(s.pc, s.ptk, s.ptgt);
            if ($urandom_range(0, 5) == 0) s.ptk = ~s.ptk;
            model_pred(s.lpc, s.e_tk, s.e_tgt);
            s.e_mis = s.v && ((s.ptk != s.tk) || (s.tk && (s.ptgt != s.tgt)));
            drive(s);
            #2;
            got = sb.pop_front();
            checks++;
            if ({pred_taken, pred_target, mispredict} !== {got.taken, got.target, got.mis}) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random[%0d] lpc=%h upc=%h: got %b/%h mis=%b want %b/%h mis=%b", n, s.lpc, s.pc,
                             pred_taken, pred_target, mispredict, got.taken, got.target, got.mis);
                bad++;
            end
            model_update(s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL random_cnt: got upd=%0d mis=%0d want %0d/%0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
        end
        go_idle();
    endtask

    task automatic test_cnt_saturate();
        // Non-mispredicting updates (miss, not taken) against a preloaded upd_cnt.
        @(negedge clk);
        force dut.upd_cnt = 32'hFFFF_FFFF;
        upd_valid = 1'b1; upd_pc = 32'h600; upd_taken = 1'b0; upd_is_jump = 1'b0;
        upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h604; flush_all = 1'b0;
        @(posedge clk);
        #1 release dut.upd_cnt;
        @(posedge clk);
        #1;
        go_idle();
        #2;
        checks++;
        if (upd_cnt !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL upd_cnt_saturate: got %h want ffffffff", upd_cnt);
        end
        checks++;
        if (mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL mis_cnt_hold: got %0d want %0d", mispred_cnt, exp_mis);
        end
        // Mispredicting updates against a preloaded mispred_cnt.
        @(negedge clk);
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        upd_valid = 1'b1; upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'h800;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h704;
        @(posedge clk);
        #1 release dut.mispred_cnt;
        @(posedge clk);
        #1;
        go_idle();
        #2;
        checks++;
        if (mispred_cnt !== 32'hFFFF_FFFF || upd_cnt !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mis_cnt_saturate: got mis=%h upd=%h want ffffffff/ffffffff", mispred_cnt, upd_cnt);
        end
    endtask

    task automatic test_reset_mid_update();
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_is_jump = 1'b0;
        upd_target = 32'h700; upd_pred_taken = 1'b0; upd_pred_target = 32'h304;
        flush_all = 1'b0; lookup_pc = 32'h300;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h304 || upd_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_async: got %b/%h upd=%h mis=%h want 0/00000304 0/0",
                     pred_taken, pred_target, upd_cnt, mispred_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rstn      = 1'b1;
        exp_upd   = '0;
        exp_mis   = '0;
        for (int k = 0; k < 2; k++) begin
            lookup_pc = (k == 0) ? 32'h300 : 32'h100;
            #2;
            checks++;
            if (pred_taken !== 1'b0 || pred_target !== lookup_pc + 32'd4) begin
                failures++;
                $display("FAIL reset_drop[%0d]: got %b/%h want 0/%h", k, pred_taken, pred_target, lookup_pc + 32'd4);
            end
        end
        checks++;
        if (upd_cnt !== exp_upd || mispred_cnt !== exp_mis) begin
            failures++;
            $display("FAIL reset_drop_cnt: got upd=%0d mis=%0d want 0/0", upd_cnt, mispred_cnt);
        end
    endtask

    initial begin
        lookup_pc       = 32'h100;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_is_jump     = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        flush_all       = 1'b0;
        test_reset();
        test_alloc();
        test_counter_sat();
        test_alias();
        test_jump_flush();
        test_back_to_back();
        test_random();
        test_cnt_saturate();
        test_reset_mid_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
